// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: FSM encodings and the default
// memDone timeout.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StWait   = 2'b01,
    StHalted = 2'b10
  } memState_t;

  localparam int unsigned TimeoutDefault = 64;

endpackage

// File: rtl/mem_wait_ctrl.sv
// Access sequencing for the memory stage: FSM plus saturating timeout counter.
// Emits the request/stall levels and the strobes that steer the MEM/WB registers.
module mem_wait_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic unaligned,
  input  logic memDone,
  input  logic resultHalt,
  output logic memEnable,
  output logic memStall,
  output logic capture,
  output logic latch,
  output logic bubble,
  output logic errStrobe,
  output logic waiting
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  memState_t stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic enable;

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    enable    = 1'b0;
    capture   = 1'b0;
    latch     = 1'b0;
    bubble    = 1'b0;
    errStrobe = 1'b0;
    case (stateQ)
      StIdle: begin
        if (!access) begin
          capture = 1'b1;
          if (resultHalt) stateD = StHalted;
        end else if (unaligned) begin
          errStrobe = 1'b1;
          stateD    = StHalted;
        end else begin
          enable = 1'b1;
          if (memDone) begin
            capture = 1'b1;
            if (resultHalt) stateD = StHalted;
          end else begin
            latch  = 1'b1;
            bubble = 1'b1;
            cntD   = CntW'(1);
            stateD = StWait;
          end
        end
      end
      StWait: begin
        // The request is withdrawn once the budget is spent; a late memDone is ignored.
        enable = (cntQ != CntMax);
        if (enable && memDone) begin
          capture = 1'b1;
          cntD    = '0;
          stateD  = resultHalt ? StHalted : StIdle;
        end else if (!enable) begin
          errStrobe = 1'b1;
          stateD    = StHalted;
        end else begin
          bubble = 1'b1;
          cntD   = cntQ + CntW'(1);
        end
      end
      StHalted: ;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  assign memEnable = enable & ~rst;
  assign memStall  = enable & ~memDone & ~rst;
  assign waiting   = (stateQ == StWait);

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-memory requests, stalls upstream while
// an access is outstanding, and registers results into the MEM/WB fields.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inXOut,
  input  logic [15:0] inRead2Data,
  input  logic [15:0] inPlusTwoPC,
  input  logic [2:0]  inWriteRegister,
  input  logic        inMemoryWrite,
  input  logic        inMemoryRead,
  input  logic        inMemoryToRegister,
  input  logic        inRegisterWrite,
  input  logic        inHalt,
  input  logic        inCreateDump,
  input  logic        inLink,
  output logic        memEnable,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memDataIn,
  input  logic [15:0] memDataOut,
  input  logic        memDone,
  output logic        memStall,
  output logic [15:0] outXout,
  output logic [15:0] outReadData,
  output logic [15:0] outPlusTwoPC,
  output logic [2:0]  outWriteRegister,
  output logic        outMemoryToRegister,
  output logic        outRegisterWrite,
  output logic        outLink,
  output logic        outHalt,
  output logic        outCreateDump,
  output logic        outErr
);

  logic access, capture, latch, bubble, errStrobe, waiting;

  logic [15:0] holdAddr, holdData, holdPc;
  logic [2:0]  holdWreg;
  logic        holdWr, holdRd, holdM2r, holdRw, holdHalt, holdDump, holdLink;

  logic [15:0] srcAddr, srcData, srcPc;
  logic [2:0]  srcWreg;
  logic        srcWr, srcRd, srcM2r, srcRw, srcHalt, srcDump, srcLink;

  assign access = inMemoryRead | inMemoryWrite;

  // Once waiting, everything comes from the hold registers, not the frozen EX/MEM.
  assign srcAddr = waiting ? holdAddr : inXOut;
  assign srcData = waiting ? holdData : inRead2Data;
  assign srcPc   = waiting ? holdPc   : inPlusTwoPC;
  assign srcWreg = waiting ? holdWreg : inWriteRegister;
  assign srcWr   = waiting ? holdWr   : inMemoryWrite;
  assign srcRd   = waiting ? holdRd   : (inMemoryRead & ~inMemoryWrite);
  assign srcM2r  = waiting ? holdM2r  : inMemoryToRegister;
  assign srcRw   = waiting ? holdRw   : inRegisterWrite;
  assign srcHalt = waiting ? holdHalt : inHalt;
  assign srcDump = waiting ? holdDump : inCreateDump;
  assign srcLink = waiting ? holdLink : inLink;

  assign memAddr   = srcAddr;
  assign memDataIn = srcData;
  assign memWr     = srcWr;

  mem_wait_ctrl #(
    .TIMEOUT(TIMEOUT)
  ) uCtrl (
    .clk       (clk),
    .rst       (rst),
    .access    (access),
    .unaligned (inXOut[0]),
    .memDone   (memDone),
    .resultHalt(srcHalt),
    .memEnable (memEnable),
    .memStall  (memStall),
    .capture   (capture),
    .latch     (latch),
    .bubble    (bubble),
    .errStrobe (errStrobe),
    .waiting   (waiting)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      holdAddr <= '0;
      holdData <= '0;
      holdPc   <= '0;
      holdWreg <= '0;
      holdWr   <= 1'b0;
      holdRd   <= 1'b0;
      holdM2r  <= 1'b0;
      holdRw   <= 1'b0;
      holdHalt <= 1'b0;
      holdDump <= 1'b0;
      holdLink <= 1'b0;
    end else if (latch) begin
      holdAddr <= inXOut;
      holdData <= inRead2Data;
      holdPc   <= inPlusTwoPC;
      holdWreg <= inWriteRegister;
      holdWr   <= inMemoryWrite;
      holdRd   <= inMemoryRead & ~inMemoryWrite;
      holdM2r  <= inMemoryToRegister;
      holdRw   <= inRegisterWrite;
      holdHalt <= inHalt;
      holdDump <= inCreateDump;
      holdLink <= inLink;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outXout             <= '0;
      outReadData         <= '0;
      outPlusTwoPC        <= '0;
      outWriteRegister    <= '0;
      outMemoryToRegister <= 1'b0;
      outRegisterWrite    <= 1'b0;
      outLink             <= 1'b0;
      outHalt             <= 1'b0;
      outCreateDump       <= 1'b0;
      outErr              <= 1'b0;
    end else if (capture) begin
      outXout             <= srcAddr;
      outReadData         <= srcRd ? memDataOut : 16'h0000;
      outPlusTwoPC        <= srcPc;
      outWriteRegister    <= srcWreg;
      outMemoryToRegister <= srcM2r;
      outRegisterWrite    <= srcRw;
      outLink             <= srcLink;
      outHalt             <= srcHalt;
      outCreateDump       <= srcDump;
    end else if (errStrobe) begin
      outErr           <= 1'b1;
      outHalt          <= 1'b1;
      outRegisterWrite <= 1'b0;
    end else if (bubble) begin
      outRegisterWrite <= 1'b0;
      outHalt          <= 1'b0;
      outCreateDump    <= 1'b0;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline. Consumes the EX/MEM register outputs, drives a multi-cycle data memory through a request/done handshake, and stalls the upstream pipeline while an access is outstanding. Registers its results into the MEM/WB fields it owns. Traps unaligned accesses and memory timeouts as an error halt.

## Interface
Parameters:
- TIMEOUT, 64: max wait cycles for `memDone` before error; width of counter = clog2(TIMEOUT+1)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- inXOut  in  16  ALU result; memory address on access
- inRead2Data  in  16  store data
- inPlusTwoPC  in  16  PC+2 for link
- inWriteRegister  in  3  destination register
- inMemoryWrite, inMemoryRead, inMemoryToRegister, inRegisterWrite, inHalt, inCreateDump, inLink  in  1 each  control from EX/MEM
- memEnable  out  1  access request, level, held until done
- memWr  out  1  1=write, 0=read; valid with memEnable
- memAddr  out  16  access address
- memDataIn  out  16  write data
- memDataOut  in  16  read data, valid when memDone=1
- memDone  in  1  access complete this cycle
- memStall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- outXout, outReadData, outPlusTwoPC  out  16 each  to MEM/WB
- outWriteRegister  out  3  to MEM/WB
- outMemoryToRegister, outRegisterWrite, outLink, outHalt, outCreateDump  out  1 each  to MEM/WB
- outErr  out  1  sticky error flag

## Operation
- access = inMemoryRead | inMemoryWrite (both set: treat as write)
- States: IDLE, WAIT, HALTED
- IDLE, no access: pass inputs to outputs next edge; outReadData=0
- IDLE, access, inXOut[0]=1 (unaligned): no request; next edge outErr=1, outHalt=1, outRegisterWrite=0 → HALTED
- IDLE, access, aligned: memEnable=1 combinationally with memAddr=inXOut, memDataIn=inRead2Data, memWr=inMemoryWrite
  - memDone same cycle: result registered, stay IDLE, no stall
  - else: latch addr/data/wr and all control into hold regs, → WAIT, memStall=1, counter=1
- WAIT: memEnable=1 from hold regs; memStall = !memDone
  - memDone=1: capture memDataOut into outReadData (reads), register held control → IDLE
  - memDone=0, counter==TIMEOUT: memEnable drops, outErr=1, outHalt=1, outRegisterWrite=0 → HALTED
  - else counter+1
- While memStall=1 and not completing: outputs get a bubble (outRegisterWrite=0, outHalt=0, outCreateDump=0, other fields hold)
- inHalt/inCreateDump without access: pass through; registered outHalt=1 → HALTED
- HALTED: memEnable=0, memStall=0, outputs hold, outErr holds; exit only by rst
- memEnable, memStall forced 0 while rst=1

## Timing
- Reset (sync): state=IDLE, counter=0, every out* register and outErr = 0
- Non-memory op and zero-wait access: 1-cycle latency, no stall
- N-cycle memory (memDone on Nth cycle after request, N≥1): memStall high N cycles; MEM/WB write on edge ending memDone cycle
- memDone ignored when memEnable=0
- Reset during WAIT: IDLE next edge, request dropped, captured data discarded
- Upstream inputs must be stable while memStall=1 (EX/MEM frozen); block uses hold regs regardless
- Counter saturates, never wraps

## Structure
- Shared constants file: state encodings (IDLE=2'b00, WAIT=2'b01, HALTED=2'b10), TIMEOUT default
- Output registers built from existing `dff` cells with reset
- One sub-module natural: `mem_wait_ctrl` (FSM + timeout counter, emits memEnable/memStall/capture/err strobes); datapath muxing stays in `mem_stage`

## Test plan
- ADD result 0x1234, rd=3, no access → next cycle outXout=0x1234, outRegisterWrite=1, memEnable never high, memStall=0
- LD addr 0x0010, memDone same cycle with memDataOut=0xBEEF → outReadData=0xBEEF, outMemoryToRegister=1, zero stall cycles
- ST addr 0x0020 data 0x5A5A, memDone on 4th cycle → memStall high 4 cycles, memAddr/memDataIn/memWr stable throughout, outRegisterWrite=0 during bubble
- LD addr 0x0013 → no memEnable; next cycle outErr=1, outHalt=1; later ops ignored until rst
- TIMEOUT=4, memDone never asserted → memEnable high 4 cycles, then outErr=1, outHalt=1, memStall=0
- rst asserted in 2nd WAIT cycle → next cycle memEnable=0, all outputs 0, new LD proceeds normally
